// File: rtl/vec_op_sequencer_if.sv
// CFU command/response handshake plus the register-file micro-op bus and
// datapath result feedback for the vector op sequencer.
interface vec_op_sequencer_if #(
  parameter int REG_IDX_W = 5
);
  logic                 cmd_valid;
  logic                 cmd_ready;
  logic [9:0]           cmd_payload_function_id;
  logic [31:0]          cmd_payload_inputs_0;
  logic [31:0]          cmd_payload_inputs_1;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [31:0]          rsp_payload_outputs_0;
  logic                 uop_valid;
  logic [REG_IDX_W-1:0] uop_op0_sel;
  logic [REG_IDX_W-1:0] uop_op1_sel;
  logic [REG_IDX_W-1:0] uop_wb_sel;
  logic                 uop_wb_en;
  logic [9:0]           uop_func;
  logic [31:0]          dp_result;

  modport master (
    output cmd_valid, cmd_payload_function_id, cmd_payload_inputs_0,
           cmd_payload_inputs_1, rsp_ready, dp_result,
    input  cmd_ready, rsp_valid, rsp_payload_outputs_0,
           uop_valid, uop_op0_sel, uop_op1_sel, uop_wb_sel, uop_wb_en, uop_func
  );

  modport slave (
    input  cmd_valid, cmd_payload_function_id, cmd_payload_inputs_0,
           cmd_payload_inputs_1, rsp_ready, dp_result,
    output cmd_ready, rsp_valid, rsp_payload_outputs_0,
           uop_valid, uop_op0_sel, uop_op1_sel, uop_wb_sel, uop_wb_en, uop_func
  );
endinterface

// File: rtl/vec_op_sequencer.sv
// Vector CFU sequencer: owns vtype, expands each vector command into one
// register-file micro-op per register of the LMUL group, returns a result.
module vec_op_sequencer #(
  parameter int         REG_IDX_W = 5,
  parameter logic [2:0] CFG_FID   = 3'd7
) (
  input  logic        clk,
  input  logic        reset_n,
  vec_op_sequencer_if.slave bus,
  output logic [31:0] vtype,
  output logic [2:0]  vlmul
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  typedef struct packed {
    logic                 valid;
    logic [REG_IDX_W-1:0] op0;
    logic [REG_IDX_W-1:0] op1;
    logic [REG_IDX_W-1:0] wb;
    logic                 wb_en;
    logic [9:0]           func;
  } uop_t;

  state_t      state, state_nxt;
  uop_t        uop;
  logic [31:0] result;
  logic [2:0]  k, last, g_last;
  logic        is_cfg;
  logic        unused_bits;

  assign is_cfg      = (bus.cmd_payload_function_id[2:0] == CFG_FID);
  assign unused_bits = ^bus.cmd_payload_inputs_1[31:REG_IDX_W];
  assign vlmul       = vtype[2:0];

  // Fractional/reserved LMUL encodings collapse to a single-register group.
  always_comb begin
    g_last = 3'd0;
    case (vlmul)
      3'd1:    g_last = 3'd1;
      3'd2:    g_last = 3'd3;
      3'd3:    g_last = 3'd7;
      default: g_last = 3'd0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.cmd_valid) state_nxt = is_cfg ? RESP : ISSUE;
      ISSUE:   if (k == last)     state_nxt = RESP;
      RESP:    if (bus.rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Micro-op bus is registered; indices step by one and wrap at REG_IDX_W bits.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vtype  <= '0;
      result <= '0;
      uop    <= '0;
      k      <= '0;
      last   <= '0;
    end else begin
      case (state)
        IDLE: if (bus.cmd_valid) begin
          if (is_cfg) begin
            vtype  <= bus.cmd_payload_inputs_0;
            result <= bus.cmd_payload_inputs_0;
          end else begin
            uop.valid <= 1'b1;
            uop.op0   <= bus.cmd_payload_inputs_0[8 +: REG_IDX_W];
            uop.op1   <= bus.cmd_payload_inputs_1[REG_IDX_W-1:0];
            uop.wb    <= bus.cmd_payload_inputs_0[REG_IDX_W-1:0];
            uop.wb_en <= bus.cmd_payload_function_id[3];
            uop.func  <= bus.cmd_payload_function_id;
            k         <= '0;
            last      <= g_last;
          end
        end
        ISSUE: begin
          if (k == last) begin
            result <= bus.dp_result;
            uop    <= '0;
          end else begin
            k       <= k + 3'd1;
            uop.op0 <= uop.op0 + REG_IDX_W'(1);
            uop.op1 <= uop.op1 + REG_IDX_W'(1);
            uop.wb  <= uop.wb  + REG_IDX_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.cmd_ready             = (state == IDLE);
  assign bus.rsp_valid             = (state == RESP);
  assign bus.rsp_payload_outputs_0 = result;
  assign bus.uop_valid             = uop.valid;
  assign bus.uop_op0_sel           = uop.op0;
  assign bus.uop_op1_sel           = uop.op1;
  assign bus.uop_wb_sel            = uop.wb;
  assign bus.uop_wb_en             = uop.wb_en;
  assign bus.uop_func              = uop.func;

endmodule

// File: tb/tb_vec_op_sequencer.sv
// Directed table-driven bench for vec_op_sequencer: config + vector commands,
// wrap, reserved LMUL, response backpressure and reset mid-sequence.
module tb_vec_op_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] vtype;
  logic [2:0]  vlmul;
  int          n_vec = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  vec_op_sequencer_if #(.REG_IDX_W(5)) bus ();

  vec_op_sequencer #(.REG_IDX_W(5), .CFG_FID(3'd7)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave),
    .vtype   (vtype),
    .vlmul   (vlmul)
  );

  typedef struct {
    logic [31:0] vt;
    logic [9:0]  fid;
    logic [4:0]  vd, vs1, vs2;
    logic [31:0] dp_base;
    int          g;
    logic [31:0] pay;
    logic [4:0]  last_wb;
    bit          hold;
  } vec_t;

  vec_t tbl [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Entered at posedge+1 in IDLE with rsp_ready=1.
  task automatic cfg(input logic [31:0] v);
    bus.cmd_valid               = 1'b1;
    bus.cmd_payload_function_id = 10'h007;
    bus.cmd_payload_inputs_0    = v;
    bus.cmd_payload_inputs_1    = 32'h0;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    chk("cfg_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    chk("cfg_payload",   bus.rsp_payload_outputs_0, v);
    chk("cfg_vtype",     vtype, v);
    chk("cfg_vlmul",     32'(vlmul), {29'b0, v[2:0]});
    chk("cfg_no_uop",    32'(bus.uop_valid), 32'd0);
    @(posedge clk); #1;
    chk("cfg_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    chk("cfg_rsp_drop",  32'(bus.rsp_valid), 32'd0);
  endtask

  task automatic run_vec(input vec_t r);
    logic [4:0] e0, e1, ew;
    bus.cmd_payload_function_id = r.fid;
    bus.cmd_payload_inputs_0    = {19'b0, r.vs1, 3'b0, r.vd};
    bus.cmd_payload_inputs_1    = {27'b0, r.vs2};
    bus.dp_result               = 32'hBAD0_0000;
    bus.cmd_valid               = 1'b1;
    if (r.hold) bus.rsp_ready = 1'b0;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    for (int i = 0; i < r.g; i++) begin
      e0 = r.vs1 + 5'(i);
      e1 = r.vs2 + 5'(i);
      ew = r.vd  + 5'(i);
      bus.dp_result = r.dp_base + 32'(i);
      chk("uop_valid", 32'(bus.uop_valid),   32'd1);
      chk("op0_sel",   32'(bus.uop_op0_sel), 32'(e0));
      chk("op1_sel",   32'(bus.uop_op1_sel), 32'(e1));
      chk("wb_sel",    32'(bus.uop_wb_sel),  32'(ew));
      chk("wb_en",     32'(bus.uop_wb_en),   32'(r.fid[3]));
      chk("uop_func",  32'(bus.uop_func),    32'(r.fid));
      chk("busy_cmd_ready", 32'(bus.cmd_ready), 32'd0);
      chk("early_rsp", 32'(bus.rsp_valid),   32'd0);
      if (i == r.g - 1) chk("last_wb_sel", 32'(bus.uop_wb_sel), 32'(r.last_wb));
      @(posedge clk); #1;
    end
    bus.dp_result = 32'h0;
    chk("rsp_valid",   32'(bus.rsp_valid), 32'd1);
    chk("uop_done",    32'(bus.uop_valid), 32'd0);
    chk("wb_en_idle",  32'(bus.uop_wb_en), 32'd0);
    chk("rsp_payload", bus.rsp_payload_outputs_0, r.pay);
    if (r.hold) begin
      bus.cmd_valid               = 1'b1;
      bus.cmd_payload_function_id = 10'h007;
      bus.cmd_payload_inputs_0    = 32'hDEAD_BEE3;
      repeat (10) begin
        @(posedge clk); #1;
        chk("hold_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        chk("hold_payload",   bus.rsp_payload_outputs_0, r.pay);
        chk("hold_cmd_ready", 32'(bus.cmd_ready), 32'd0);
        chk("hold_vtype",     vtype, r.vt);
      end
      bus.cmd_valid = 1'b0;
      bus.rsp_ready = 1'b1;
    end
    @(posedge clk); #1;
    chk("post_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    chk("post_rsp_valid", 32'(bus.rsp_valid), 32'd0);
  endtask

  initial begin
    //         vtype           fid      vd  vs1 vs2 dp_base         g  payload         last_wb hold
    tbl[0] = '{32'h2,          10'h008, 4,  8,  12, 32'h0000_0100,  4, 32'h0000_0103,  5'd7,  1'b0};
    tbl[1] = '{32'h3,          10'h00B, 30, 28, 0,  32'h0000_2000,  8, 32'h0000_2007,  5'd5,  1'b0};
    tbl[2] = '{32'h5,          10'h001, 1,  2,  3,  32'h0000_ABC0,  1, 32'h0000_ABC0,  5'd1,  1'b0};
    tbl[3] = '{32'h0,          10'h010, 31, 31, 31, 32'h0000_0055,  1, 32'h0000_0055,  5'd31, 1'b0};
    tbl[4] = '{32'h1,          10'h3F9, 10, 0,  20, 32'hFFFF_FFFE,  2, 32'hFFFF_FFFF,  5'd11, 1'b1};
    tbl[5] = '{32'h8000_0007,  10'h00A, 6,  17, 9,  32'h0000_0077,  1, 32'h0000_0077,  5'd6,  1'b0};

    reset_n                     = 1'b0;
    bus.cmd_valid               = 1'b0;
    bus.cmd_payload_function_id = '0;
    bus.cmd_payload_inputs_0    = '0;
    bus.cmd_payload_inputs_1    = '0;
    bus.rsp_ready               = 1'b1;
    bus.dp_result               = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_vtype",     vtype, 32'd0);
    chk("rst_uop_valid", 32'(bus.uop_valid), 32'd0);
    chk("rst_payload",   bus.rsp_payload_outputs_0, 32'd0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 6; i++) begin
      cfg(tbl[i].vt);
      run_vec(tbl[i]);
    end

    // Reset in the middle of an 8-register group.
    cfg(32'h3);
    bus.cmd_payload_function_id = 10'h008;
    bus.cmd_payload_inputs_0    = {19'b0, 5'd3, 3'b0, 5'd9};
    bus.cmd_payload_inputs_1    = 32'd4;
    bus.cmd_valid               = 1'b1;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    @(posedge clk); #1;
    chk("mid_uop_valid", 32'(bus.uop_valid),  32'd1);
    chk("mid_wb_sel",    32'(bus.uop_wb_sel), 32'd10);
    reset_n = 1'b0;
    #1;
    chk("arst_uop_valid", 32'(bus.uop_valid),   32'd0);
    chk("arst_wb_en",     32'(bus.uop_wb_en),   32'd0);
    chk("arst_op0",       32'(bus.uop_op0_sel), 32'd0);
    chk("arst_wb_sel",    32'(bus.uop_wb_sel),  32'd0);
    chk("arst_func",      32'(bus.uop_func),    32'd0);
    chk("arst_rsp_valid", 32'(bus.rsp_valid),   32'd0);
    chk("arst_cmd_ready", 32'(bus.cmd_ready),   32'd1);
    chk("arst_vtype",     vtype, 32'd0);
    chk("arst_vlmul",     32'(vlmul), 32'd0);
    chk("arst_payload",   bus.rsp_payload_outputs_0, 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      chk("post_rst_uop",  32'(bus.uop_valid), 32'd0);
      chk("post_rst_rsp",  32'(bus.rsp_valid), 32'd0);
      chk("post_rst_rdy",  32'(bus.cmd_ready), 32'd1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
